seq_addsub: RTL and testbench

SEQ_ADDSUB -- requirements
Module: seq_addsub

---
 rtl/seq_addsub.sv | 160 ++++++++++++++++
 tb/tb_seq_addsub.sv | 126 ++++++++++++
 2 files changed

// File: rtl/seq_addsub.sv
// rtl/seq_addsub.sv - serial add/subtract that ripples one SLICE-bit chunk per clock.
// Subtract yields |a-b| with neg set when a<b, via an optional two's-complement second pass.
module seq_addsub #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             m,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum,
    output logic             neg
);

    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             m_q, m_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH:0]   sum_q, sum_d;
    logic             neg_q, neg_d;

    logic [SLICE-1:0] a_sl, b_sl, r_sl;
    logic [SLICE:0]   slice_sum;
    logic             c_out;
    logic             last_slice;
    logic [WIDTH-1:0] res_new;

    // Slice selection by compare against constant positions keeps every part-select static.
    always_comb begin
        a_sl    = '0;
        b_sl    = '0;
        r_sl    = '0;
        res_new = res_q;
        for (int k = 0; k < N; k++) begin
            if (idx_q == CW'(k)) begin
                a_sl = a_q[k*SLICE +: SLICE];
                b_sl = b_q[k*SLICE +: SLICE];
                r_sl = res_q[k*SLICE +: SLICE];
            end
        end
        if (state_q == PASS2) begin
            slice_sum = {1'b0, ~r_sl} + {{SLICE{1'b0}}, carry_q};
        end else begin
            slice_sum = {1'b0, a_sl} + {1'b0, b_sl ^ {SLICE{m_q}}} + {{SLICE{1'b0}}, carry_q};
        end
        c_out = slice_sum[SLICE];
        for (int k = 0; k < N; k++) begin
            if (idx_q == CW'(k)) begin
                res_new[k*SLICE +: SLICE] = slice_sum[SLICE-1:0];
            end
        end
        last_slice = (idx_q == CW'(N - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= 1'b0;
            res_q   <= '0;
            sum_q   <= '0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            m_q     <= m_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            neg_q   <= neg_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = PASS1;
            PASS1:   if (last_slice) state_d = (!m_q || c_out) ? DONE : PASS2;
            PASS2:   if (last_slice) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        sum       = sum_q;
        neg       = neg_q;
    end

    // Datapath next state; sum/neg only load on the edge that finishes the last pass.
    always_comb begin
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        m_d     = m_q;
        res_d   = res_q;
        sum_d   = sum_q;
        neg_d   = neg_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    m_d     = m;
                    idx_d   = '0;
                    carry_d = m;
                end
            end
            PASS1: begin
                res_d   = res_new;
                carry_d = c_out;
                if (last_slice) begin
                    idx_d = '0;
                    if (!m_q || c_out) begin
                        sum_d = {(m_q ? 1'b0 : c_out), res_new};
                        neg_d = 1'b0;
                    end else begin
                        carry_d = 1'b1;
                    end
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            PASS2: begin
                res_d   = res_new;
                carry_d = c_out;
                if (last_slice) begin
                    idx_d = '0;
                    sum_d = {1'b0, res_new};
                    neg_d = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_seq_addsub.sv
// tb/tb_seq_addsub.sv - directed-vector bench for seq_addsub (WIDTH=16, SLICE=4).
module tb_seq_addsub;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        m = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [16:0] sum;
    logic        neg;

    int n_vec  = 0;
    int n_miss = 0;

    seq_addsub #(.WIDTH(16), .SLICE(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .m(m), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .neg(neg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input string tag, input logic [15:0] ta, input logic [15:0] tbv,
                         input logic tm, input logic [16:0] es, input logic en,
                         input int el, input int hold);
        int          cnt;
        logic        rdy_seen;
        logic        unstable;
        logic [16:0] s0;
        logic        n0;
        check({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
        a = ta; b = tbv; m = tm; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = ~ta; b = ~tbv; m = ~tm;
        cnt = 0;
        rdy_seen = 1'b0;
        while (!out_valid && cnt < 40) begin
            if (in_ready) rdy_seen = 1'b1;
            tick();
            cnt++;
        end
        check({tag, "_latency"}, 32'(cnt), 32'(el));
        check({tag, "_busy_ready"}, 32'(rdy_seen), 32'd0);
        check({tag, "_sum"}, 32'(sum), 32'(es));
        check({tag, "_neg"}, 32'(neg), 32'(en));
        s0 = sum;
        n0 = neg;
        unstable = 1'b0;
        for (int i = 0; i < hold; i++) begin
            a = 16'(i * 16'h1357); b = ~a;
            tick();
            if (!out_valid || sum !== s0 || neg !== n0) unstable = 1'b1;
        end
        if (hold > 0) check({tag, "_hold_stable"}, 32'(unstable), 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_ret_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_ret_valid"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic seen_valid;
        rst = 1'b1;
        in_valid = 1'b1;
        a = 16'h1111; b = 16'h2222;
        tick();
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_neg", 32'(neg), 32'd0);

        do_op("add_ovf",  16'hFFFF, 16'h0001, 1'b0, 17'h10000, 1'b0, 4, 0);
        do_op("sub_gt",   16'h1234, 16'h0234, 1'b1, 17'h01000, 1'b0, 4, 0);
        do_op("sub_lt",   16'h0005, 16'h0009, 1'b1, 17'h00004, 1'b1, 8, 0);
        do_op("sub_eq",   16'hABCD, 16'hABCD, 1'b1, 17'h00000, 1'b0, 4, 0);
        do_op("bp_add",   16'h1234, 16'h4321, 1'b0, 17'h05555, 1'b0, 4, 3);
        do_op("bp_sub",   16'h0000, 16'hFFFF, 1'b1, 17'h0FFFF, 1'b1, 8, 3);
        do_op("add_max",  16'hFFFF, 16'hFFFF, 1'b0, 17'h1FFFE, 1'b0, 4, 0);

        // Abort a subtract-with-borrow during the third cycle of its second pass.
        a = 16'h0005; b = 16'h0009; m = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_sum", 32'(sum), 32'd0);
        check("midrst_neg", 32'(neg), 32'd0);
        seen_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid) seen_valid = 1'b1;
        end
        check("midrst_no_result", 32'(seen_valid), 32'd0);
        do_op("post_rst", 16'h0001, 16'h0002, 1'b0, 17'h00003, 1'b0, 4, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
